// File: rtl/matvec_ctrl.sv
// Sequencing controller for a K x K matrix-vector multiply: loads matrix and
// vector words into synchronous-read memories, then streams one row dot product at a time.
module matvec_ctrl #(
  parameter int K   = 8,
  parameter int MAW = $clog2(K*K),
  parameter int XAW = $clog2(K)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           input_valid,
  output logic           input_ready,
  input  logic           new_matrix,
  output logic           output_valid,
  input  logic           output_ready,
  output logic           m_wr_en,
  output logic [MAW-1:0] m_addr,
  output logic           x_wr_en,
  output logic [XAW-1:0] x_addr,
  output logic           acc_clear,
  output logic           acc_en,
  output logic           have_matrix
);

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_LOAD_M = 3'd1,
    ST_LOAD_X = 3'd2,
    ST_MAC    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_OUT    = 3'd5
  } state_t;

  localparam logic [MAW-1:0] M_ZERO   = {MAW{1'b0}};
  localparam logic [MAW-1:0] M_ONE    = MAW'(1);
  localparam logic [MAW-1:0] M_LAST   = MAW'(K*K-1);
  localparam logic [MAW-1:0] X_LAST_M = MAW'(K-1);
  localparam logic [XAW-1:0] X_ZERO   = {XAW{1'b0}};
  localparam logic [XAW-1:0] X_ONE    = XAW'(1);
  localparam logic [XAW-1:0] X_LAST   = XAW'(K-1);

  state_t         state_r, next_state_s;
  logic [MAW-1:0] count_r, count_next_s;
  logic [XAW-1:0] row_r, row_next_s;
  logic [XAW-1:0] col_r, col_next_s;
  logic           have_matrix_r, have_next_s;
  logic           acc_pend_r, clr_pend_r;

  // The accumulator consumes memory read data one cycle after the MAC address
  // is issued, so its strobes are delayed copies of the MAC state.
  assign acc_en      = acc_pend_r;
  assign acc_clear   = clr_pend_r;
  assign have_matrix = have_matrix_r;

  // State, counters and delayed accumulator strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_WAIT;
      count_r       <= M_ZERO;
      row_r         <= X_ZERO;
      col_r         <= X_ZERO;
      have_matrix_r <= 1'b0;
      acc_pend_r    <= 1'b0;
      clr_pend_r    <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      count_r       <= count_next_s;
      row_r         <= row_next_s;
      col_r         <= col_next_s;
      have_matrix_r <= have_next_s;
      acc_pend_r    <= (state_r == ST_MAC);
      clr_pend_r    <= (state_r == ST_MAC) && (col_r == X_ZERO);
    end
  end

  // Next-state logic and combinational output decode
  always_comb begin
    next_state_s = state_r;
    count_next_s = count_r;
    row_next_s   = row_r;
    col_next_s   = col_r;
    have_next_s  = have_matrix_r;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    m_wr_en      = 1'b0;
    x_wr_en      = 1'b0;
    m_addr       = M_ZERO;
    x_addr       = X_ZERO;
    case (state_r)
      ST_WAIT: begin
        input_ready = 1'b1;
        if (input_valid) begin
          // A problem without a stored matrix must bring one along.
          if (new_matrix || !have_matrix_r) begin
            m_wr_en      = 1'b1;
            have_next_s  = 1'b0;
            count_next_s = M_ONE;
            next_state_s = ST_LOAD_M;
          end else begin
            x_wr_en      = 1'b1;
            count_next_s = M_ONE;
            next_state_s = ST_LOAD_X;
          end
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_LOAD_M: begin
        input_ready = 1'b1;
        m_addr      = count_r;
        if (input_valid) begin
          m_wr_en = 1'b1;
          if (count_r == M_LAST) begin
            have_next_s  = 1'b1;
            count_next_s = M_ZERO;
            next_state_s = ST_LOAD_X;
          end else begin
            count_next_s = count_r + M_ONE;
          end
        end else begin
          next_state_s = ST_LOAD_M;
        end
      end
      ST_LOAD_X: begin
        input_ready = 1'b1;
        x_addr      = XAW'(count_r);
        if (input_valid) begin
          x_wr_en = 1'b1;
          if (count_r == X_LAST_M) begin
            count_next_s = M_ZERO;
            row_next_s   = X_ZERO;
            col_next_s   = X_ZERO;
            next_state_s = ST_MAC;
          end else begin
            count_next_s = count_r + M_ONE;
          end
        end else begin
          next_state_s = ST_LOAD_X;
        end
      end
      ST_MAC: begin
        // K is a power of two, so r*K + c is a plain concatenation.
        m_addr     = MAW'({row_r, col_r});
        x_addr     = col_r;
        col_next_s = col_r + X_ONE;
        if (col_r == X_LAST) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_MAC;
        end
      end
      ST_DRAIN: begin
        next_state_s = ST_OUT;
      end
      ST_OUT: begin
        output_valid = 1'b1;
        if (output_ready) begin
          col_next_s = X_ZERO;
          if (row_r == X_LAST) begin
            row_next_s   = X_ZERO;
            next_state_s = ST_WAIT;
          end else begin
            row_next_s   = row_r + X_ONE;
            next_state_s = ST_MAC;
          end
        end else begin
          next_state_s = ST_OUT;
        end
      end
      default: begin
        next_state_s = ST_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_matvec_ctrl.sv
// Self-checking bench for matvec_ctrl: behavioural memories and accumulator
// driven by the controller's strobes, row results compared against dot products of the sent data.
module tb_matvec_ctrl;
  localparam int K   = 8;
  localparam int NM  = K*K;
  localparam int MAW = $clog2(K*K);
  localparam int XAW = $clog2(K);

  logic           clk;
  logic           reset;
  logic           input_valid;
  logic           input_ready;
  logic           new_matrix;
  logic           output_valid;
  logic           output_ready;
  logic           m_wr_en;
  logic [MAW-1:0] m_addr;
  logic           x_wr_en;
  logic [XAW-1:0] x_addr;
  logic           acc_clear;
  logic           acc_en;
  logic           have_matrix;

  logic [7:0]  data_word;
  logic [7:0]  mem_m [NM];
  logic [7:0]  mem_x [K];
  logic [7:0]  m_rd, x_rd;
  logic [31:0] acc;

  int sent_m [NM];
  int sent_x [K];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c0       = 0;
  bit model_have = 1'b0;

  matvec_ctrl #(.K(K)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .new_matrix   (new_matrix),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .m_wr_en      (m_wr_en),
    .m_addr       (m_addr),
    .x_wr_en      (x_wr_en),
    .x_addr       (x_addr),
    .acc_clear    (acc_clear),
    .acc_en       (acc_en),
    .have_matrix  (have_matrix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories and the accumulator the controller steers
  always @(posedge clk) begin
    if (m_wr_en) mem_m[m_addr] <= data_word;
    if (x_wr_en) mem_x[x_addr] <= data_word;
    m_rd <= mem_m[m_addr];
    x_rd <= mem_x[x_addr];
    if (acc_en) acc <= acc_clear ? 32'(m_rd) * 32'(x_rd) : acc + 32'(m_rd) * 32'(x_rd);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "global timeout");
  end

  function automatic int row_dot(input int r);
    int s = 0;
    for (int c = 0; c < K; c++) s += sent_m[r*K + c] * sent_x[c];
    return s;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_input_ready"}, input_ready, 1'b1);
    chk1({tag, "_output_valid"}, output_valid, 1'b0);
    chk1({tag, "_m_wr_en"}, m_wr_en, 1'b0);
    chk1({tag, "_x_wr_en"}, x_wr_en, 1'b0);
    chk1({tag, "_acc_en"}, acc_en, 1'b0);
    chk1({tag, "_acc_clear"}, acc_clear, 1'b0);
    chk32({tag, "_m_addr"}, 32'(m_addr), 32'd0);
    chk32({tag, "_x_addr"}, 32'(x_addr), 32'd0);
    chk1({tag, "_have_matrix"}, have_matrix, 1'b0);
  endtask

  // Feed one problem's words; a matrix is expected whenever requested or none is stored.
  task automatic load(input bit newm, input int vpct, output int nwords);
    bit mload, v;
    int idx, guard, xi;
    mload  = newm || !model_have;
    nwords = mload ? NM + K : K;
    if (mload) for (int i = 0; i < NM; i++) sent_m[i] = $urandom_range(0, 255);
    for (int i = 0; i < K; i++) sent_x[i] = $urandom_range(0, 255);
    idx = 0;
    guard = 0;
    while (idx < nwords && guard < 20 * nwords + 100) begin
      @(negedge clk);
      guard++;
      v = ($urandom_range(0, 99) < vpct);
      if (idx == 0) c0 = cyc;
      xi = mload ? idx - NM : idx;
      if (xi < 0) xi = 0;
      input_valid  = v;
      output_ready = 1'($urandom_range(0, 1));
      new_matrix   = (idx == 0) ? newm : 1'($urandom_range(0, 1));
      data_word    = (mload && idx < NM) ? 8'(sent_m[idx]) : 8'(sent_x[xi]);
      #1;
      chk1("load_input_ready", input_ready, 1'b1);
      chk1("load_acc_en", acc_en, 1'b0);
      chk1("load_output_valid", output_valid, 1'b0);
      if (mload && idx < NM) begin
        chk1("m_wr_en", m_wr_en, v);
        chk32("m_addr", 32'(m_addr), idx);
        chk1("m_phase_x_wr_en", x_wr_en, 1'b0);
        if (idx > 0) chk1("have_matrix_loading", have_matrix, 1'b0);
      end else begin
        chk1("x_wr_en", x_wr_en, v);
        chk32("x_addr", 32'(x_addr), xi);
        chk1("x_phase_m_wr_en", m_wr_en, 1'b0);
        chk1("have_matrix_x_phase", have_matrix, 1'b1);
      end
      if (v) idx++;
    end
    if (idx < nwords) chk32("load_timeout", idx, nwords);
    model_have = 1'b1;
  endtask

  // Collect K rows; timed runs also check the cycle of each result.
  task automatic rows(input int rpct, input int hold0, input int nwords, input bit timed);
    bit seen, done, rdy;
    int clears, guard, hold_left;
    logic [31:0] held_acc;
    for (int r = 0; r < K; r++) begin
      seen = 1'b0;
      done = 1'b0;
      clears = 0;
      guard = 0;
      held_acc = 32'd0;
      hold_left = (r == 0) ? hold0 : 0;
      while (!done && guard < 200) begin
        @(negedge clk);
        guard++;
        rdy = (hold_left > 0) ? 1'b0 : ($urandom_range(0, 99) < rpct);
        output_ready = rdy;
        input_valid  = 1'($urandom_range(0, 1));
        new_matrix   = 1'($urandom_range(0, 1));
        data_word    = 8'($urandom_range(0, 255));
        #1;
        chk1("busy_input_ready", input_ready, 1'b0);
        chk1("busy_m_wr_en", m_wr_en, 1'b0);
        chk1("busy_x_wr_en", x_wr_en, 1'b0);
        if (!output_valid) begin
          chk1("output_valid_dropped", seen, 1'b0);
          if (acc_en && acc_clear) clears++;
        end else begin
          chk1("out_acc_en", acc_en, 1'b0);
          chk1("out_acc_clear", acc_clear, 1'b0);
          if (!seen) begin
            seen = 1'b1;
            held_acc = acc;
            chk32("row_result", acc, row_dot(r));
            chk32("acc_clear_per_row", clears, 1);
            if (timed) chk32("first_valid_cycle", cyc - c0 + 1, nwords + (r + 1) * (K + 2));
          end else begin
            chk32("result_held", acc, held_acc);
          end
          if (hold_left > 0) hold_left--;
          if (rdy) begin
            done = 1'b1;
            if (timed && r == K - 1) chk32("last_handshake_cycle", cyc - c0 + 1, nwords + K * (K + 2));
          end
        end
      end
      if (!done) chk1("row_timeout", done, 1'b1);
    end
    @(negedge clk);
    input_valid  = 1'b0;
    output_ready = 1'b0;
    #1;
    chk1("idle_input_ready", input_ready, 1'b1);
    chk1("idle_output_valid", output_valid, 1'b0);
    chk32("idle_m_addr", 32'(m_addr), 32'd0);
    chk32("idle_x_addr", 32'(x_addr), 32'd0);
  endtask

  initial begin
    int nw;
    reset        = 1'b1;
    input_valid  = 1'b0;
    output_ready = 1'b0;
    new_matrix   = 1'b0;
    data_word    = 8'd0;
    acc          = 32'd0;
    #1 reset = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 check_reset_outputs("after_release");

    load(1'b1, 100, nw);
    chk1("have_after_first", have_matrix, 1'b1);
    rows(100, 0, nw, 1'b1);

    load(1'b0, 100, nw);
    chk32("reuse_word_count", nw, K);
    rows(100, 0, nw, 1'b1);

    for (int p = 0; p < 3; p++) begin
      load(1'($urandom_range(0, 1)), 50, nw);
      rows(50, (p == 0) ? 20 : 0, nw, 1'b0);
    end

    // Abort a matrix load partway through with reset.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      input_valid = 1'b1;
      new_matrix  = 1'b1;
      data_word   = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    input_valid = 1'b0;
    #1;
    chk32("mid_load_m_addr", 32'(m_addr), 32'd30);
    #1 reset = 1'b0;
    #1 check_reset_outputs("mid_load_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_have = 1'b0;
    load(1'b0, 50, nw);
    chk32("forced_reload_words", nw, NM + K);
    rows(50, 0, nw, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
